fetch_unit: RTL

Instruction-fetch front end for the 9-bit stack machine. It drives the 8-bit program counter into the combinational instruction ROM, registers the returned machine word into an instruction register (IR) for the datapath, and applies taken-branch redirects with a one-slot squash. It detects the HALT word, runs stall-aware start/halt control, and keeps a retired-instruction count.

---
 rtl/stack_isa_pkg.sv | 14 +
 rtl/fetch_unit.sv | 71 +++++++
 2 files changed

// File: rtl/stack_isa_pkg.sv
// stack_isa_pkg: shared widths, HALT word, opcodes and fetch states for the 9-bit stack machine
package stack_isa_pkg;
    localparam int INST_W = 9;
    localparam int PC_W   = 8;
    localparam logic [INST_W-1:0] HALT_WORD = 9'h1FF;
    localparam logic [7:0] ADD   = 8'h00;
    localparam logic [7:0] BNE   = 8'h06;
    localparam logic [7:0] PCNT  = 8'h08;
    localparam logic [7:0] CPY   = 8'h0B;
    localparam logic [7:0] LDCNT = 8'h0C;
    localparam logic [7:0] PBAR  = 8'h12;
    localparam logic [7:0] ADDC  = 8'h13;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_e;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR front end with one-slot branch squash, HALT detect and retired count
module fetch_unit
    import stack_isa_pkg::*;
(
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              start,
    output logic [PC_W-1:0]   PC,
    input  logic [INST_W-1:0] inst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    output logic [INST_W-1:0] ir,
    output logic              ir_valid,
    output logic              halted,
    output logic [15:0]       icount
);
    fetch_state_e      state_q;
    logic [PC_W-1:0]   pc_q;
    logic [INST_W-1:0] ir_q;
    logic              ir_valid_q;
    logic              halted_q;
    logic [15:0]       icount_q;
    logic [15:0]       icount_d;
    // retired count sticks at all-ones instead of wrapping
    always_comb icount_d = (icount_q == 16'hFFFF) ? icount_q : icount_q + 16'd1;
    // fetch FSM: state change first, then stall > branch squash > HALT > sequential fetch
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            icount_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) state_q <= RUN;
                RUN: if (!stall) begin
                    if (branch_taken) begin
                        pc_q       <= branch_target;
                        ir_valid_q <= 1'b0;
                    end else if (inst == HALT_WORD) begin
                        ir_q       <= HALT_WORD;
                        ir_valid_q <= 1'b0;
                        halted_q   <= 1'b1;
                        state_q    <= HALTED;
                    end else begin
                        ir_q       <= inst;
                        ir_valid_q <= 1'b1;
                        pc_q       <= pc_q + 8'd1;
                        icount_q   <= icount_d;
                    end
                end
                HALTED: if (start) begin
                    halted_q   <= 1'b0;
                    icount_q   <= '0;
                    ir_valid_q <= 1'b0;
                    pc_q       <= '0;
                    state_q    <= RUN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign PC       = pc_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;
    assign icount   = icount_q;
endmodule
